// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war referee.
// State and player encodings plus the score helper.
package tow_pkg;

    localparam int SCORE_W = 3;

    typedef enum logic [1:0] {
        PLAY,
        WIN,
        RESTART,
        OVER
    } state_e;

    typedef enum logic [1:0] {
        P_NONE,
        P_L,
        P_R
    } player_e;

    // Saturating score increment: never wraps past max.
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s,
        input logic [SCORE_W-1:0] max
    );
        return (s < max) ? s + SCORE_W'(1) : max;
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// 10-bit Fibonacci LFSR, taps 10 and 7, advances on en.
// Drives the computer player's press decision.
module tow_lfsr #(
    parameter logic [9:0] SEED = 10'h001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] q
);

    // Shift left, feedback from bits 10 and 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[8:0], q[9] ^ q[6]};
        end
    end

endmodule

// File: rtl/tow_referee.sv
// Round/match sequencer for the tug-of-war light field.
// Define TOW_CPU_PLAYER_EN to make the right player the computer.
module tow_referee
    import tow_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_MAX   = 7,
    parameter int HOLD_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l_press,
    input  logic                  r_press,
    input  logic [NUM_LIGHTS-1:0] lights,
    output logic                  l_out,
    output logic                  r_out,
    output logic                  play_again,
    output logic                  winner_l,
    output logic                  winner_r,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r,
    output logic                  match_over
`ifdef TOW_CPU_PLAYER_EN
    ,
    input  logic [2:0]            cpu_level
`endif
);

    localparam logic [SCORE_W-1:0] SMAX =
        SCORE_W'(SCORE_MAX);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);

    state_e          state;
    logic [HW-1:0]   hold_cnt;
    logic            r_in;
    logic            in_play;
    player_e         win_p;
    logic [SCORE_W-1:0] next_l;
    logic [SCORE_W-1:0] next_r;

    // Only the two end lights decide a round.
    logic unused_lights;
    assign unused_lights = ^lights;

`ifdef TOW_CPU_PLAYER_EN
    logic [9:0] div_cnt;
    logic       tick;
    logic [9:0] lfsr_q;
    logic       unused_cpu;

    assign tick = (div_cnt == 10'h3ff);
    assign unused_cpu = ^{r_press, lfsr_q[9:3]};

    // Free-running divider: one press decision per 1024 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 10'd1;
        end
    end

    tow_lfsr #(
        .SEED (10'h001)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .q     (lfsr_q)
    );

    assign r_in = tick & (lfsr_q[2:0] < cpu_level);
`else
    assign r_in = r_press;
`endif

    assign in_play = (state == PLAY) & ~reset;
    assign l_out   = in_play & l_press;
    assign r_out   = in_play & r_in;

    assign next_l = sat_inc(score_l, SMAX);
    assign next_r = sat_inc(score_r, SMAX);

    // Decode a round win; simultaneous presses never win.
    always_comb begin
        win_p = P_NONE;
        unique case (1'b1)
            lights[NUM_LIGHTS-1] & l_press & ~r_in:
                win_p = P_L;
            lights[0] & r_in & ~l_press:
                win_p = P_R;
            default:
                win_p = P_NONE;
        endcase
    end

    // Round sequencer with registered scores and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            hold_cnt   <= '0;
            score_l    <= '0;
            score_r    <= '0;
            winner_l   <= 1'b0;
            winner_r   <= 1'b0;
            play_again <= 1'b0;
            match_over <= 1'b0;
        end else begin
            play_again <= 1'b0;
            unique case (state)
                PLAY: begin
                    hold_cnt <= '0;
                    unique case (win_p)
                        P_L: begin
                            score_l  <= next_l;
                            winner_l <= 1'b1;
                            if (next_l == SMAX) begin
                                state      <= OVER;
                                match_over <= 1'b1;
                            end else begin
                                state <= WIN;
                            end
                        end
                        P_R: begin
                            score_r  <= next_r;
                            winner_r <= 1'b1;
                            if (next_r == SMAX) begin
                                state      <= OVER;
                                match_over <= 1'b1;
                            end else begin
                                state <= WIN;
                            end
                        end
                        default: ;
                    endcase
                end
                WIN: begin
                    if (hold_cnt == HMAX) begin
                        state      <= RESTART;
                        hold_cnt   <= '0;
                        play_again <= 1'b1;
                        winner_l   <= 1'b0;
                        winner_r   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RESTART: begin
                    state <= PLAY;
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tow_referee.sv
// Directed scoreboard bench for tow_referee.
// HOLD_CYCLES=4, SCORE_MAX=3, NUM_LIGHTS=9.
module tb_tow_referee;

    logic       clk;
    logic       reset;
    logic       l_press;
    logic       r_press;
    logic [8:0] lights;
    logic       l_out;
    logic       r_out;
    logic       play_again;
    logic       winner_l;
    logic       winner_r;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic       match_over;
`ifdef TOW_CPU_PLAYER_EN
    logic [2:0] cpu_level;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef enum int {
        S_LOUT, S_ROUT, S_PA, S_WL,
        S_WR, S_SL, S_SR, S_MO
    } sig_e;

    typedef struct {
        sig_e       sig;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    tow_referee #(
        .NUM_LIGHTS  (9),
        .SCORE_MAX   (3),
        .HOLD_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l_press    (l_press),
        .r_press    (r_press),
        .lights     (lights),
        .l_out      (l_out),
        .r_out      (r_out),
        .play_again (play_again),
        .winner_l   (winner_l),
        .winner_r   (winner_r),
        .score_l    (score_l),
        .score_r    (score_r),
        .match_over (match_over)
`ifdef TOW_CPU_PLAYER_EN
        ,
        .cpu_level  (cpu_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs(sig_e s);
        case (s)
            S_LOUT:  return {7'd0, l_out};
            S_ROUT:  return {7'd0, r_out};
            S_PA:    return {7'd0, play_again};
            S_WL:    return {7'd0, winner_l};
            S_WR:    return {7'd0, winner_r};
            S_SL:    return {5'd0, score_l};
            S_SR:    return {5'd0, score_r};
            default: return {7'd0, match_over};
        endcase
    endfunction

    task automatic exp_v(string tag, sig_e s,
                         logic [7:0] v);
        exp_t e;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [7:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            n_checks++;
            assert (o === e.val) else begin
                n_fails++;
                $error("FAIL %s observed=%0h expected=%0h",
                       e.tag, o, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        l_press = 1'b0;
        r_press = 1'b0;
        lights  = 9'h000;
`ifdef TOW_CPU_PLAYER_EN
        cpu_level = 3'd0;
`endif
        // 1: reset
        step();
        l_press = 1'b1;
        step();
        exp_v("rst_lout", S_LOUT, 0);
        exp_v("rst_rout", S_ROUT, 0);
        exp_v("rst_pa",   S_PA,   0);
        exp_v("rst_wl",   S_WL,   0);
        exp_v("rst_wr",   S_WR,   0);
        exp_v("rst_sl",   S_SL,   0);
        exp_v("rst_sr",   S_SR,   0);
        exp_v("rst_mo",   S_MO,   0);
        check_now();
        reset = 1'b0;
        step();
        exp_v("play_lout", S_LOUT, 1);
        exp_v("play_rout", S_ROUT, 0);
        check_now();
        l_press = 1'b0;

        // 2: left round win
        lights  = 9'h100;
        l_press = 1'b1;
        exp_v("win_fwd", S_LOUT, 1);
        check_now();
        step();
        l_press = 1'b1;
        exp_v("win_sl",   S_SL,   1);
        exp_v("win_wl",   S_WL,   1);
        exp_v("win_wr",   S_WR,   0);
        exp_v("win_blk",  S_LOUT, 0);
        exp_v("win_pa",   S_PA,   0);
        check_now();
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_v("hold_pa",  S_PA,   0);
            exp_v("hold_wl",  S_WL,   1);
            exp_v("hold_blk", S_LOUT, 0);
            check_now();
        end
        step();
        exp_v("rs_pa",  S_PA,   1);
        exp_v("rs_wl",  S_WL,   0);
        exp_v("rs_blk", S_LOUT, 0);
        check_now();
        l_press = 1'b0;
        step();
        exp_v("post_pa", S_PA, 0);
        exp_v("post_sl", S_SL, 1);
        check_now();
        lights = 9'h000;

        // 3: simultaneous presses at right edge
        lights  = 9'h001;
        l_press = 1'b1;
        r_press = 1'b1;
        exp_v("both_l", S_LOUT, 1);
        exp_v("both_r", S_ROUT, 1);
        check_now();
        step();
        l_press = 1'b0;
        r_press = 1'b0;
        exp_v("both_wl", S_WL, 0);
        exp_v("both_wr", S_WR, 0);
        exp_v("both_sl", S_SL, 1);
        exp_v("both_sr", S_SR, 0);
        check_now();

        // 4: right wins the match
        for (int k = 1; k <= 3; k++) begin
            r_press = 1'b1;
            step();
            r_press = 1'b0;
            exp_v("rw_sr", S_SR, 8'(k));
            exp_v("rw_wr", S_WR, 1);
            check_now();
            if (k < 3) begin
                for (int j = 1; j <= 6; j++) begin
                    step();
                    if (j == 5) begin
                        exp_v("rw_pa", S_PA, 1);
                        check_now();
                    end
                end
            end
        end
        l_press = 1'b1;
        r_press = 1'b1;
        exp_v("over_mo", S_MO, 1);
        check_now();
        for (int i = 0; i < 20; i++) begin
            step();
            exp_v("over_pa", S_PA,   0);
            exp_v("over_mo", S_MO,   1);
            exp_v("over_wr", S_WR,   1);
            exp_v("over_wl", S_WL,   0);
            exp_v("over_l",  S_LOUT, 0);
            exp_v("over_r",  S_ROUT, 0);
            exp_v("over_sr", S_SR,   3);
            exp_v("over_sl", S_SL,   1);
            check_now();
        end
        reset   = 1'b1;
        l_press = 1'b0;
        r_press = 1'b0;
        step();
        reset  = 1'b0;
        lights = 9'h000;
        exp_v("orst_sl", S_SL, 0);
        exp_v("orst_sr", S_SR, 0);
        exp_v("orst_mo", S_MO, 0);
        exp_v("orst_wr", S_WR, 0);
        check_now();
        r_press = 1'b1;
        exp_v("orst_r", S_ROUT, 1);
        check_now();
        r_press = 1'b0;

        // 5: reset during the hold
        lights  = 9'h100;
        l_press = 1'b1;
        step();
        l_press = 1'b0;
        exp_v("mid_wl", S_WL, 1);
        exp_v("mid_sl", S_SL, 1);
        check_now();
        step();
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        lights = 9'h000;
        exp_v("mrst_sl", S_SL, 0);
        exp_v("mrst_wl", S_WL, 0);
        exp_v("mrst_pa", S_PA, 0);
        check_now();
        for (int i = 0; i < 8; i++) begin
            step();
            exp_v("mrst_nopa", S_PA, 0);
            check_now();
        end
        l_press = 1'b1;
        exp_v("mrst_l", S_LOUT, 1);
        check_now();
        l_press = 1'b0;

`ifdef TOW_CPU_PLAYER_EN
        // 6: computer player
        begin
            int pulses;
            int last;
            r_press   = 1'b1;
            cpu_level = 3'd0;
            pulses    = 0;
            for (int i = 0; i < 5000; i++) begin
                step();
                if (r_out) pulses++;
            end
            n_checks++;
            assert (pulses === 0) else begin
                n_fails++;
                $error("FAIL cpu0 observed=%0d expected=0",
                       pulses);
            end
            cpu_level = 3'd7;
            pulses    = 0;
            last      = -1;
            for (int i = 0; i < 5000; i++) begin
                step();
                if (r_out) begin
                    if (last >= 0) begin
                        n_checks++;
                        assert (((i - last) % 1024) === 0)
                        else begin
                            n_fails++;
                            $error("FAIL cpu_gap observed=%0d expected=0",
                                   (i - last) % 1024);
                        end
                    end
                    last = i;
                    pulses++;
                end
            end
            n_checks++;
            assert (pulses > 0) else begin
                n_fails++;
                $error("FAIL cpu7 observed=%0d expected=>0",
                       pulses);
            end
            r_press = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
